// File: rtl/sysid_check_ctrl.sv
// System-ID check controller: reads sysid words 0/1 after reset or on start, compares them, then shares the slave with one host read master.
// Optional macro SYSID_CHECK_RETRY_EN retries a failed check up to twice; fsm_state exposes the FSM for debug.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
    parameter int          RD_LATENCY  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        host_read,
    input  logic        host_address,
    output logic        host_waitrequest,
    output logic [31:0] host_readdata,
    output logic        host_readdatavalid,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_IDLE    = 3'd5,
        ST_HOST    = 3'd6
    } state_t;

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $error("sysid_check_ctrl: RD_LATENCY must be in 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic        cnt_zero;
    logic        id_match;
    logic        ts_match;
    logic        retry_go;

    assign cnt_zero  = (cnt == 4'd0);
    assign id_match  = (sid_readdata == EXPECTED_ID);
    assign ts_match  = (sid_readdata == EXPECTED_TS);
    assign fsm_state = state;

`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0] attempt;
    // id_ok already holds this attempt's ID result when the timestamp is sampled.
    assign retry_go = (!id_ok || !ts_match) && (attempt != 2'd2);
`else
    assign retry_go = 1'b0;
`endif

    always_comb begin
        state_n          = state;
        host_waitrequest = 1'b1;
        case (state)
            ST_INIT:    state_n = ST_RD_ID;
            ST_RD_ID:   state_n = ST_WAIT_ID;
            ST_WAIT_ID: if (cnt_zero) state_n = ST_RD_TS;
            ST_RD_TS:   state_n = ST_WAIT_TS;
            ST_WAIT_TS: if (cnt_zero) state_n = retry_go ? ST_RD_ID : ST_IDLE;
            ST_IDLE: begin
                // A re-check request wins over a host read in the same cycle.
                if (start) begin
                    state_n = ST_INIT;
                end else begin
                    host_waitrequest = 1'b0;
                    if (host_read) state_n = ST_HOST;
                end
            end
            ST_HOST:    if (cnt_zero) state_n = ST_IDLE;
            default:    state_n = ST_INIT;
        endcase
        if (reset) host_waitrequest = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_INIT;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt                <= 4'd0;
            sid_address        <= 1'b0;
            host_readdata      <= 32'd0;
            host_readdatavalid <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            id_ok              <= 1'b0;
            ts_ok              <= 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
            attempt            <= 2'd0;
`endif
        end else begin
            host_readdatavalid <= 1'b0;
            case (state)
                ST_INIT: begin
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    id_ok <= 1'b0;
                    ts_ok <= 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
                    attempt <= 2'd0;
`endif
                end
                ST_RD_ID: begin
                    sid_address <= 1'b0;
                    cnt         <= LAT_M1;
                end
                ST_WAIT_ID: begin
                    if (cnt_zero) id_ok <= id_match;
                    else          cnt   <= cnt - 4'd1;
                end
                ST_RD_TS: begin
                    sid_address <= 1'b1;
                    cnt         <= LAT_M1;
                end
                ST_WAIT_TS: begin
                    if (cnt_zero) begin
                        ts_ok <= ts_match;
                        if (!retry_go) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
`ifdef SYSID_CHECK_RETRY_EN
                        if (retry_go) attempt <= attempt + 2'd1;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (!start && host_read) begin
                        sid_address <= host_address;
                        cnt         <= LAT_M1;
                    end
                end
                ST_HOST: begin
                    if (cnt_zero) begin
                        host_readdata      <= sid_readdata;
                        host_readdatavalid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: vector table of checks, hand-written corner sequences, randomized traffic
// against a word-level slave/host model with a data/latency scoreboard.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h67C7_7EC2;
    localparam int          LAT    = 3;   // slave model below assumes LAT >= 2
    localparam int          CHECK_CYCLES = 2 * (LAT + 1);

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        host_read;
    logic        host_address;
    logic        host_waitrequest;
    logic [31:0] host_readdata;
    logic        host_readdatavalid;
    logic        sid_address;
    logic [31:0] sid_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] id_val;
    logic [31:0] ts_val;
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] last_exp = 32'd0;

    sysid_check_ctrl #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .RD_LATENCY  (LAT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .host_read          (host_read),
        .host_address       (host_address),
        .host_waitrequest   (host_waitrequest),
        .host_readdata      (host_readdata),
        .host_readdatavalid (host_readdatavalid),
        .sid_address        (sid_address),
        .sid_readdata       (sid_readdata),
        .busy               (busy),
        .done               (done),
        .id_ok              (id_ok),
        .ts_ok              (ts_ok),
        .fsm_state          (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Slave model: data is only valid once the address has been stable for LAT cycles.
    logic [LAT-2:0] hist = '0;
    always @(posedge clock) hist <= {hist, sid_address};
    function automatic logic [31:0] slave_word(input logic a);
        return a ? ts_val : id_val;
    endfunction
    assign sid_readdata = (hist == {(LAT-1){sid_address}}) ? slave_word(sid_address) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int attempts(input logic pass);
`ifdef SYSID_CHECK_RETRY_EN
        return pass ? 1 : 3;
`else
        return 1;
`endif
    endfunction

    // Scoreboard: every accepted host read must return its word exactly LAT+1 cycles later.
    always @(negedge clock) begin
        if (host_readdatavalid) begin
            if (exp_q.size() == 0) begin
                chk("rdv_unexpected", 32'(host_readdatavalid), 32'd0);
            end else begin
                chk("rdv_data", host_readdata, exp_q[0]);
                chk("rdv_cycle", cyc, due_q[0]);
                last_exp = exp_q.pop_front();
                void'(due_q.pop_front());
            end
        end
        if (due_q.size() != 0 && cyc > due_q[0]) begin
            chk("rdv_missing", 32'(host_readdatavalid), 32'd1);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        if (reset) begin
            exp_q.delete();
            due_q.delete();
        end else if (host_read && !host_waitrequest) begin
            exp_q.push_back(slave_word(host_address));
            due_q.push_back(cyc + LAT + 1);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string p);
        chk({p, "_waitrequest"}, 32'(host_waitrequest), 32'd1);
        chk({p, "_readdata"}, host_readdata, 32'd0);
        chk({p, "_rdv"}, 32'(host_readdatavalid), 32'd0);
        chk({p, "_sid_address"}, 32'(sid_address), 32'd0);
        chk({p, "_busy"}, 32'(busy), 32'd0);
        chk({p, "_done"}, 32'(done), 32'd0);
        chk({p, "_id_ok"}, 32'(id_ok), 32'd0);
        chk({p, "_ts_ok"}, 32'(ts_ok), 32'd0);
    endtask

    // Counts cycles from the current one (k=0) until done rises after busy was seen.
    task automatic wait_done(input int exp_k, input string name);
        int  k = 0;
        bit  seen_busy = 0;
        int  wr_bad = 0;
        while (k < 300) begin
            @(negedge clock);
            if (busy && !seen_busy) begin
                seen_busy = 1;
                chk({name, "_done_clr"}, 32'(done), 32'd0);
            end
            if (seen_busy && done) break;
            if (!host_waitrequest) wr_bad++;
            @(posedge clock);
            #1;
            start = 1'b0;
            k++;
        end
        chk({name, "_latency"}, k, exp_k);
        chk({name, "_wr_high"}, wr_bad, 0);
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic run_check(input logic [31:0] idw, input logic [31:0] tsw, input string name);
        logic pass;
        tick();
        id_val = idw;
        ts_val = tsw;
        start  = 1'b1;
        pass   = (idw == EXP_ID) && (tsw == EXP_TS);
        wait_done(2 + attempts(pass) * CHECK_CYCLES, name);
        chk({name, "_id_ok"}, 32'(id_ok), 32'(idw == EXP_ID));
        chk({name, "_ts_ok"}, 32'(ts_ok), 32'(tsw == EXP_TS));
    endtask

    task automatic wait_accept(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!host_waitrequest) break;
        end
        chk({name, "_accept"}, 32'(host_waitrequest), 32'd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic host_rd(input logic a, input string name);
        tick();
        host_read    = 1'b1;
        host_address = a;
        wait_accept(name);
        tick();
        host_read = 1'b0;
        drain(name);
    endtask

    typedef struct {
        logic [31:0] id_w;
        logic [31:0] ts_w;
        logic        exp_id_ok;
        logic        exp_ts_ok;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic sv_done, sv_id, sv_ts;
        int   phase;

        vecs[0] = '{32'h0000_0000, 32'h67C7_7EC2, 1'b1, 1'b1};
        vecs[1] = '{32'h0000_0000, 32'h67C7_7EC3, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0001, 32'h67C7_7EC2, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'hE7C7_7EC2, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h67C7_7EC2, 1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; host_read = 1'b0; host_address = 1'b0;
        id_val = EXP_ID; ts_val = EXP_TS;
        repeat (3) tick();
        @(negedge clock);
        check_reset_values("reset");

        tick();
        reset = 1'b0;
        wait_done(1 + CHECK_CYCLES, "boot");
        chk("boot_id_ok", 32'(id_ok), 32'd1);
        chk("boot_ts_ok", 32'(ts_ok), 32'd1);

        // vector table
        for (int i = 0; i < 6; i++) begin
            logic pass;
            tick();
            id_val = vecs[i].id_w;
            ts_val = vecs[i].ts_w;
            start  = 1'b1;
            pass   = vecs[i].exp_id_ok && vecs[i].exp_ts_ok;
            wait_done(2 + attempts(pass) * CHECK_CYCLES, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_id_ok", i), 32'(id_ok), 32'(vecs[i].exp_id_ok));
            chk($sformatf("vec%0d_ts_ok", i), 32'(ts_ok), 32'(vecs[i].exp_ts_ok));
        end

        // host read of the timestamp word, then readdata must hold across a check
        host_rd(1'b1, "host_ts");
        chk("host_ts_value", last_exp, EXP_TS);
        run_check(32'h1234_5678, EXP_TS, "hold_chk");
        chk("hold_readdata", host_readdata, EXP_TS);
        host_rd(1'b0, "host_id");

        // start and host_read in the same IDLE cycle
        tick();
        id_val = EXP_ID; ts_val = EXP_TS;
        start = 1'b1; host_read = 1'b1; host_address = 1'b1;
        wait_done(2 + CHECK_CYCLES, "start_and_read");
        chk("start_and_read_accept", 32'(host_waitrequest), 32'd0);
        tick();
        host_read = 1'b0;
        drain("start_and_read");

        // start pulsed while a host read is in flight
        sv_done = done; sv_id = id_ok; sv_ts = ts_ok;
        tick();
        host_read = 1'b1; host_address = 1'b0;
        wait_accept("start_in_host");
        tick();
        host_read = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        drain("start_in_host");
        tick();
        @(negedge clock);
        chk("start_in_host_busy", 32'(busy), 32'd0);
        chk("start_in_host_wr", 32'(host_waitrequest), 32'd0);
        chk("start_in_host_done", 32'(done), 32'(sv_done));
        chk("start_in_host_id_ok", 32'(id_ok), 32'(sv_id));
        chk("start_in_host_ts_ok", 32'(ts_ok), 32'(sv_ts));

        // reset one cycle into WAIT_TS
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        phase = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (busy && !sid_address) phase = 1;
            else if (phase == 1 && sid_address) begin phase = 2; break; end
        end
        chk("mid_ts_reached", phase, 2);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        check_reset_values("mid_ts_reset");
        tick();
        reset = 1'b0;
        wait_done(1 + CHECK_CYCLES, "mid_ts_rerun");
        chk("mid_ts_rerun_ok", 32'(id_ok & ts_ok), 32'd1);

        // reset during a host read: no data strobe afterwards
        tick();
        host_read = 1'b1; host_address = 1'b1;
        wait_accept("mid_host");
        tick();
        host_read = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_done(1 + CHECK_CYCLES, "mid_host_rerun");

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            case ($urandom_range(0, 2))
                0: host_rd(1'($urandom_range(0, 1)), "rnd_rd");
                1: run_check($urandom_range(0, 1) ? EXP_ID : $urandom(),
                             $urandom_range(0, 1) ? EXP_TS : $urandom(), "rnd_chk");
                default: begin
                    id_val = $urandom();
                    ts_val = $urandom();
                    host_rd(1'($urandom_range(0, 1)), "rnd_rd_w");
                end
            endcase
        end

        repeat (10) tick();
        chk("no_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
